// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - time-multiplexed 7-segment scanner for packed BCD digits
// Double-buffered so a frame never mixes two values; leading-zero blanking and invalid-code dash.
module bcd_seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PRE_W = $clog2(SCAN_DIV)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done,
  output logic                    invalid
);

  localparam logic [PRE_W-1:0]      PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic                    invalid_q, invalid_d;

  logic                    slot_end, wrap;
  logic [3:0]              cur_digit;
  logic                    cur_dp, cur_blank, zero_run;
  logic [NUM_DIGITS-1:0]   blank, an_sel;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    slot_end = en && (pre_q == PRE_MAX);
    wrap     = slot_end && (idx_q == IDX_MAX);

    pre_d = pre_q;
    if (en) pre_d = slot_end ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    pend_bcd_d = load ? bcd_in : pend_bcd_q;
    pend_dp_d  = load ? dp_in  : pend_dp_q;
    // A load on the wrap edge bypasses pending so it is shown in the frame just starting.
    act_bcd_d  = wrap ? (load ? bcd_in : pend_bcd_q) : act_bcd_q;
    act_dp_d   = wrap ? (load ? dp_in  : pend_dp_q)  : act_dp_q;

    cur_digit = '0;
    cur_dp    = 1'b0;
    an_sel    = '0;
    invalid_d = 1'b0;
    zero_run  = 1'b1;
    blank     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_bcd_q[4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i > 0) && zero_run;
      if (act_bcd_q[4*i +: 4] > 4'd9) invalid_d = 1'b1;
      if (idx_q == IDX_W'(i)) begin
        cur_digit = act_bcd_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        an_sel[i] = 1'b1;
      end
    end
    cur_blank = |(blank & an_sel);

    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (en) begin
      an_d = an_sel ^ AN_OFF;
      if (!cur_blank) begin
        seg_d = seg_decode(cur_digit) ^ SEG_OFF;
        dp_d  = cur_dp ^ DP_OFF;
      end
    end
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      act_bcd_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      act_bcd_q    <= act_bcd_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      invalid_q    <= invalid_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;
  assign invalid    = invalid_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb/tb_bcd_seg_scanner.sv - randomized bench for bcd_seg_scanner against a behavioural model
module tb_bcd_seg_scanner;
  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset, en, load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done, invalid;

  int checks = 0;
  int errors = 0;

  int          ticks;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd, e_inv;
  logic [3:0]  e_an;

  logic [6:0] lit_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  bcd_seg_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done), .invalid(invalid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scan position is derived from the count of enabled cycles since reset.
  task automatic model_edge();
    int idx;
    bit wrap;
    logic [3:0] d;
    if (!reset) begin
      ticks = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0; e_inv = 1'b0;
      return;
    end
    idx = (ticks / SD) % ND;
    e_inv = 1'b0;
    for (int i = 0; i < ND; i++) if (m_act[4*i +: 4] > 4'd9) e_inv = 1'b1;
    if (en) begin
      d = m_act[4*idx +: 4];
      e_an = ~(4'b0001 << idx);
      if (idx > 0 && (m_act >> (4*idx)) == 16'h0) begin
        e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_seg = ~((d > 4'd9) ? 7'h40 : lit_tab[d]);
        e_dp  = ~m_adp[idx];
      end
    end else begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end
    wrap = en && (ticks % SD == SD - 1) && (idx == ND - 1);
    e_fd = wrap;
    if (en) ticks++;
    if (wrap) begin
      m_act = load ? bcd_in : m_pend;
      m_adp = load ? dp_in : m_pdp;
    end
    if (load) begin
      m_pend = bcd_in;
      m_pdp  = dp_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("seg", seg, e_seg);
    check_eq("an", an, e_an);
    check_eq("dp", dp, e_dp);
    check_eq("frame_done", frame_done, e_fd);
    check_eq("invalid", invalid, e_inv);
    check_eq("digit_idx", digit_idx, (ticks / SD) % ND);
  endtask

  task automatic wait_fd(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < budget);
    check_eq("frame_done_wait", frame_done, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int sig;
    logic [15:0] v;
    reset = 1'b0; en = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
    repeat (3) step();
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_dp", dp, 1);
    check_eq("rst_idx", digit_idx, 0);

    reset = 1'b1; en = 1'b1;
    do_load(16'h1234, 4'h0);
    wait_fd(40);
    step();
    check_eq("d0_an", an, 4'b1110); check_eq("d0_seg", seg, 7'h19);
    repeat (4) step();
    check_eq("d1_an", an, 4'b1101); check_eq("d1_seg", seg, 7'h30);
    repeat (4) step();
    check_eq("d2_an", an, 4'b1011); check_eq("d2_seg", seg, 7'h24);
    repeat (4) step();
    check_eq("d3_an", an, 4'b0111); check_eq("d3_seg", seg, 7'h79);

    do_load(16'h0050, 4'h0);
    wait_fd(40);
    step();
    check_eq("lz_d0", seg, 7'h40);
    repeat (4) step();
    check_eq("lz_d1", seg, 7'h12);
    repeat (8) step();
    check_eq("lz_d3_seg", seg, 7'h7F); check_eq("lz_d3_an", an, 4'b0111);

    do_load(16'h00A3, 4'h0);
    wait_fd(40);
    step();
    check_eq("inv_set", invalid, 1);
    repeat (4) step();
    check_eq("dash", seg, 7'h3F);
    do_load(16'h0003, 4'h0);
    wait_fd(40);
    check_eq("inv_hold", invalid, 1);
    step();
    check_eq("inv_clr", invalid, 0);

    do_load(16'h1111, 4'h5);
    while (ticks % (SD*ND) != SD*ND - 1) step();
    do_load(16'h2222, 4'hA);
    check_eq("bypass_fd", frame_done, 1);
    step();
    check_eq("bypass_seg", seg, 7'h24);
    step();
    en = 1'b0;
    step();
    check_eq("off_an", an, 4'hF);
    repeat (3) step();
    en = 1'b1;
    repeat (6) step();

    reset = 1'b0; load = 1'b1; bcd_in = 16'h9876;
    step();
    reset = 1'b1; load = 1'b0;
    check_eq("rst_load_an", an, 4'hF);
    step();

    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 11) == 0);
      sig   = $urandom_range(0, 4);
      v     = '0;
      for (int i = 0; i < sig; i++)
        v[4*i +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      bcd_in = v;
      dp_in  = 4'($urandom_range(0, 15));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
